inst_encoder: RTL and testbench

- Inverse of the immediate generator: packs decoded fields and a 32-bit immediate into a legal RV32I instruction word, using the team's 3-bit format-type encoding.
- Used by the boot/program loader and the self-test sequencer to build instruction memory contents on the fly.
- Valid/ready in, valid/ready out, one registered output stage.
- Checks immediate range/alignment, tags bad words, counts errors, and tracks the instruction-memory write address.

---
 rtl/inst_encoder.sv | 121 ++++++++++++
 tb/tb_inst_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields and a 32-bit immediate into an
// instruction word, flags out-of-range immediates, and tags each word with its memory address.
module inst_encoder #(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   ADDR_BASE = '0,
  parameter int unsigned         ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_type,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned INST_W = 32;

  typedef enum logic [2:0] {
    FMT_R  = 3'b000,
    FMT_I  = 3'b001,
    FMT_S  = 3'b010,
    FMT_B  = 3'b011,
    FMT_U  = 3'b100,
    FMT_J  = 3'b101,
    FMT_LI = 3'b110,
    FMT_JI = 3'b111
  } fmt_e;

  logic [INST_W-1:0] enc_inst;
  logic              enc_err;
  logic              fits_i;
  logic              fits_b;
  logic              fits_j;
  logic              accept;
  logic [ADDR_W-1:0] next_addr;

  // A signed immediate fits in N bits when every bit from N-1 upward equals the sign.
  assign fits_i = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign fits_b = (&in_imm[31:12]) || (~|in_imm[31:12]);
  assign fits_j = (&in_imm[31:20]) || (~|in_imm[31:20]);

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Field packing and immediate legality per format.
  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    case (fmt_e'(in_type))
      FMT_R: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I, FMT_LI, FMT_JI: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !fits_i;
      end
      FMT_S: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = !fits_i;
      end
      FMT_B: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = !fits_b || in_imm[0];
      end
      FMT_U: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = |in_imm[11:0];
      end
      FMT_J: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = !fits_j || in_imm[0];
      end
      default: begin
        enc_inst = '0;
        enc_err  = 1'b0;
      end
    endcase
  end

  // Output stage, address counter and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= ADDR_BASE;
      out_err   <= 1'b0;
      err_count <= '0;
      next_addr <= ADDR_BASE;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_addr  <= ADDR_BASE;
      next_addr <= ADDR_BASE;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_inst  <= enc_inst;
      out_addr  <= next_addr;
      out_err   <= enc_err;
      next_addr <= next_addr + ADDR_W'(4);
      if (enc_err && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed literal checks plus randomized traffic against a
// behavioural model; a default instance and a narrow one (4-bit address, 2-bit error count).
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;

  logic        in_ready0, out_valid0, out_err0;
  logic [31:0] out_inst0, out_addr0;
  logic [15:0] err_count0;
  logic        in_ready1, out_valid1, out_err1;
  logic [31:0] out_inst1;
  logic [3:0]  out_addr1;
  logic [1:0]  err_count1;

  always #5 clk = ~clk;

  inst_encoder u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid0), .out_ready(out_ready), .out_inst(out_inst0),
    .out_addr(out_addr0), .out_err(out_err0), .err_count(err_count0)
  );

  inst_encoder #(.ADDR_W(4), .ERR_CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid1), .out_ready(out_ready), .out_inst(out_inst1),
    .out_addr(out_addr1), .out_err(out_err1), .err_count(err_count1)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit live   = 0;

  // Model state, index 0 = default instance, 1 = narrow instance.
  bit          m_valid[2];
  bit [31:0]   m_inst[2];
  bit [31:0]   m_addr[2];
  bit [31:0]   m_nxt[2];
  bit [31:0]   m_cnt[2];
  bit          m_err[2];
  bit [31:0]   amask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  bit [31:0]   cmax[2]  = '{32'd65535, 32'd3};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word built with shifts and masks from the current input fields.
  function automatic bit [31:0] ref_inst();
    bit [31:0] imm, w;
    imm = in_imm;
    w   = 32'(in_opcode);
    case (in_type)
      3'd0: w = w | 32'(in_funct7) << 25 | 32'(in_rs2) << 20 | 32'(in_rs1) << 15
                  | 32'(in_funct3) << 12 | 32'(in_rd) << 7;
      3'd1, 3'd6, 3'd7:
            w = w | (imm & 32'hFFF) << 20 | 32'(in_rs1) << 15 | 32'(in_funct3) << 12
                  | 32'(in_rd) << 7;
      3'd2: w = w | ((imm >> 5) & 32'h7F) << 25 | 32'(in_rs2) << 20 | 32'(in_rs1) << 15
                  | 32'(in_funct3) << 12 | (imm & 32'h1F) << 7;
      3'd3: w = w | ((imm >> 12) & 32'h1) << 31 | ((imm >> 5) & 32'h3F) << 25
                  | 32'(in_rs2) << 20 | 32'(in_rs1) << 15 | 32'(in_funct3) << 12
                  | ((imm >> 1) & 32'hF) << 8 | ((imm >> 11) & 32'h1) << 7;
      3'd4: w = w | (imm & 32'hFFFF_F000) | 32'(in_rd) << 7;
      default:
            w = w | ((imm >> 20) & 32'h1) << 31 | ((imm >> 1) & 32'h3FF) << 21
                  | ((imm >> 11) & 32'h1) << 20 | ((imm >> 12) & 32'hFF) << 12
                  | 32'(in_rd) << 7;
    endcase
    return w;
  endfunction

  function automatic bit ref_err();
    longint s;
    s = longint'($signed(in_imm));
    case (in_type)
      3'd0:                   return 1'b0;
      3'd1, 3'd2, 3'd6, 3'd7: return (s < -2048) || (s > 2047);
      3'd3:                   return (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd4:                   return (in_imm % 4096) != 0;
      default:                return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
    endcase
  endfunction

  // One clock: check handshake, advance model, then compare registered outputs.
  task automatic step();
    bit rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy = !flush && (!m_valid[k] || out_ready);
      if (live) chk($sformatf("in_ready[%0d]", k), k ? in_ready1 : in_ready0, rdy);
      if (rst) begin
        m_valid[k] = 0; m_inst[k] = 0; m_addr[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_nxt[k] = 0;
      end else if (flush) begin
        m_valid[k] = 0; m_addr[k] = 0; m_nxt[k] = 0;
      end else if (in_valid && rdy) begin
        m_valid[k] = 1;
        m_inst[k]  = ref_inst();
        m_err[k]   = ref_err();
        m_addr[k]  = m_nxt[k];
        m_nxt[k]   = (m_nxt[k] + 4) & amask[k];
        if (m_err[k] && m_cnt[k] < cmax[k]) m_cnt[k]++;
      end else if (out_ready) begin
        m_valid[k] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    live = 1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid[%0d]", k), k ? out_valid1 : out_valid0, m_valid[k]);
      chk($sformatf("out_addr[%0d]", k), k ? 32'(out_addr1) : out_addr0, m_addr[k]);
      chk($sformatf("err_count[%0d]", k), k ? 32'(err_count1) : 32'(err_count0), m_cnt[k]);
      if (m_valid[k]) begin
        chk($sformatf("out_inst[%0d]", k), k ? out_inst1 : out_inst0, m_inst[k]);
        chk($sformatf("out_err[%0d]", k), k ? out_err1 : out_err0, m_err[k]);
      end
    end
  endtask

  task automatic beat(bit [2:0] t, bit [6:0] op, bit [4:0] rd, bit [2:0] f3,
                      bit [4:0] rs1, bit [4:0] rs2, bit [31:0] imm);
    in_valid = 1; in_type = t; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_funct7 = 7'h0; in_imm = imm;
  endtask

  task automatic do_flush();
    flush = 1; in_valid = 0; step(); flush = 0;
  endtask

  int bl[17] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                 -1048577, -1048576, 1048574, 1048575, 1048576, 0, 1, -1};

  function automatic bit [31:0] rnd_imm();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom_range(0, 4095)) - 2048;
      1:       v = bl[$urandom_range(0, 16)];
      2:       v = int'($urandom);
      default: v = int'($urandom & 32'hFFFF_F000);
    endcase
    return 32'(v);
  endfunction

  initial begin
    rst = 1; flush = 0; out_ready = 1;
    beat(3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 0;
    step(); step();
    chk("reset_inst", out_inst0, 32'h0);
    chk("reset_err", out_err0, 1'b0);
    rst = 0;

    // Single I beat.
    beat(3'd1, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5);
    step();
    in_valid = 0;
    chk("single_inst", out_inst0, 32'h0050_0093);
    chk("single_addr", out_addr0, 32'h0);
    chk("single_err", out_err0, 1'b0);
    step();

    // Streaming S, B, J with no bubbles.
    do_flush();
    beat(3'd2, 7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 32'd8);
    step();
    chk("s_inst", out_inst0, 32'h0020_A423);
    chk("s_addr", out_addr0, 32'h0);
    beat(3'd3, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    step();
    chk("b_inst", out_inst0, 32'hFE00_0EE3);
    chk("b_addr", out_addr0, 32'h4);
    beat(3'd5, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'h800);
    step();
    chk("j_inst", out_inst0, 32'h0010_00EF);
    chk("j_addr", out_addr0, 32'h8);
    chk("j_valid", out_valid0, 1'b1);

    // Error tagging.
    beat(3'd1, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048);
    step();
    chk("err_i_inst", out_inst0, 32'h8000_0093);
    chk("err_i_flag", out_err0, 1'b1);
    chk("err_i_cnt", err_count0, 16'd1);
    beat(3'd3, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 32'd3);
    step();
    chk("err_b_flag", out_err0, 1'b1);
    chk("err_b_cnt", err_count0, 16'd2);
    beat(3'd4, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000);
    step();
    chk("u_inst", out_inst0, 32'h1234_52B7);
    chk("u_err", out_err0, 1'b0);
    in_valid = 0; step();

    // Backpressure: word A held, B waits.
    do_flush();
    out_ready = 0;
    beat(3'd1, 7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 32'd1);
    step();
    beat(3'd1, 7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_inst", out_inst0, 32'h0010_0113);
      chk("bp_in_ready", in_ready0, 1'b0);
    end
    out_ready = 1;
    step();
    chk("bp_b_inst", out_inst0, 32'h0020_0193);
    chk("bp_b_addr", out_addr0, 32'h4);
    in_valid = 0; step();

    // Flush during a stall with a pending beat.
    out_ready = 0;
    beat(3'd1, 7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 32'd7);
    step(); step();
    flush = 1;
    step();
    chk("flush_valid", out_valid0, 1'b0);
    chk("flush_cnt", err_count0, 16'd2);
    flush = 0; out_ready = 1;
    step();
    chk("post_flush_addr", out_addr0, 32'h0);

    // Narrow instance: address wrap and counter saturation.
    do_flush();
    for (int i = 0; i < 5; i++) begin
      beat(3'd1, 7'b0010011, 5'(i), 3'd0, 5'd0, 5'd0, 32'd4096);
      step();
    end
    chk("wrap_small_addr", 32'(out_addr1), 32'h0);
    chk("wrap_big_addr", out_addr0, 32'h10);
    chk("sat_small_cnt", 32'(err_count1), 32'd3);
    chk("sat_big_cnt", 32'(err_count0), 32'd7);

    // Reset mid-stream.
    rst = 1;
    step();
    rst = 0; in_valid = 0;
    chk("rst_valid", out_valid0, 1'b0);
    chk("rst_inst", out_inst0, 32'h0);
    chk("rst_cnt", err_count0, 16'd0);
    chk("rst_small_cnt", 32'(err_count1), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      beat(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 3'($urandom),
           5'($urandom), 5'($urandom), rnd_imm());
      in_funct7 = 7'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
